ofdm_cp_insert: RTL

OFDM_CP_INSERT -- requirements
Module: ofdm_cp_insert

---
 rtl/ofdm_pkg.sv | 20 ++
 rtl/ofdm_pp_ram.sv | 38 +++
 rtl/ofdm_cp_insert.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM cyclic-prefix inserter: default geometry,
// read-side state encoding and the I/Q sample record.
package ofdm_pkg;

    localparam int N_DEFAULT      = 32;
    localparam int CP_LEN_DEFAULT = 8;
    localparam int DW_DEFAULT     = 16;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_CP   = 2'd1,
        RD_BODY = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic [DW_DEFAULT-1:0] i;
        logic [DW_DEFAULT-1:0] q;
    } sample_t;

endpackage

// File: rtl/ofdm_pp_ram.sv
// Two-bank ping-pong sample store: one write port, one registered read port.
// The bank select is the top address bit, so both banks share one array.
module ofdm_pp_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int W     = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [0:2*DEPTH-1];

    // Sample write into the selected bank; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    // Registered read: data appears one cycle after the address is presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end
    end

endmodule

// File: rtl/ofdm_cp_insert.sv
// OFDM cyclic-prefix inserter. IFFT output samples land in a ping-pong store
// by index; each completed symbol is replayed as its last CP_LEN samples
// followed by the full body, back to back when the other bank is ready.
// Optional feature macro: OFDM_CP_SYMCNT_EN adds a 16-bit emitted-symbol counter.
//
// Read FSM:
//   state   | meaning
//   RD_IDLE | no full bank to read, outputs idle
//   RD_CP   | reading addresses N-CP_LEN..N-1 (prefix)
//   RD_BODY | reading addresses 0..N-1 (body), frees the bank on the last read
module ofdm_cp_insert
    import ofdm_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int CP_LEN = CP_LEN_DEFAULT,
    parameter int DW     = DW_DEFAULT,
    localparam int AW    = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_i,
    input  logic [DW-1:0] in_q,
    input  logic [AW-1:0] in_index,
    output logic          out_valid,
    output logic [DW-1:0] out_i,
    output logic [DW-1:0] out_q,
    output logic          out_sop,
    output logic          out_eop,
    output logic          overflow
`ifdef OFDM_CP_SYMCNT_EN
    ,
    output logic [15:0]   sym_cnt
`endif
);

    localparam logic [AW-1:0] ADDR_LAST = AW'(N - 1);
    localparam logic [AW-1:0] CP_START  = AW'(N - CP_LEN);

    rd_state_t       state, state_nxt;
    logic [AW-1:0]   rd_addr, rd_addr_nxt;
    logic            rd_bank;
    logic            wr_bank;
    logic [1:0]      full, full_nxt;
    logic            wr_blocked, wr_en, wr_done;
    logic            rd_en, rd_done, other_full;
    logic [2*DW-1:0] rd_data;

    assign wr_blocked = full[wr_bank];
    assign wr_en      = in_valid && !wr_blocked;
    assign wr_done    = wr_en && (in_index == ADDR_LAST);
    assign rd_done    = (state == RD_BODY) && (rd_addr == ADDR_LAST);

    // The other bank counts as ready if a completion write lands in it on this
    // same edge; otherwise back-to-back symbols would gain an idle cycle.
    assign other_full = full[~rd_bank] || (wr_done && (wr_bank != rd_bank));

    ofdm_pp_ram #(
        .DEPTH (N),
        .AW    (AW),
        .W     (2*DW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_bank (wr_bank),
        .wr_addr (in_index),
        .wr_data ({in_i, in_q}),
        .rd_en   (rd_en),
        .rd_bank (rd_bank),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Full flags: completion sets the write bank, last body read clears the
    // read bank. They can never target the same bank on one edge.
    always_comb begin
        full_nxt = full;
        if (wr_done) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_done) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    // Write-side bank bookkeeping and drop indication.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full     <= 2'b00;
            wr_bank  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            full     <= full_nxt;
            overflow <= in_valid && wr_blocked;
            if (wr_done) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Read FSM next-state, address sequencing and read enable.
    always_comb begin
        state_nxt   = state;
        rd_addr_nxt = rd_addr;
        rd_en       = 1'b0;
        case (state)
            RD_IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt   = RD_CP;
                    rd_addr_nxt = CP_START;
                end
            end
            RD_CP: begin
                rd_en = 1'b1;
                if (rd_addr == ADDR_LAST) begin
                    state_nxt   = RD_BODY;
                    rd_addr_nxt = '0;
                end else begin
                    rd_addr_nxt = rd_addr + 1'b1;
                end
            end
            RD_BODY: begin
                rd_en = 1'b1;
                if (rd_addr == ADDR_LAST) begin
                    if (other_full) begin
                        state_nxt   = RD_CP;
                        rd_addr_nxt = CP_START;
                    end else begin
                        state_nxt   = RD_IDLE;
                        rd_addr_nxt = '0;
                    end
                end else begin
                    rd_addr_nxt = rd_addr + 1'b1;
                end
            end
            default: begin
                state_nxt   = RD_IDLE;
                rd_addr_nxt = '0;
            end
        endcase
    end

    // Read FSM state, address and bank registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RD_IDLE;
            rd_addr <= '0;
            rd_bank <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_addr <= rd_addr_nxt;
            if (rd_done) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Output strobes registered alongside the RAM read so they line up with data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else begin
            out_valid <= rd_en;
            out_sop   <= (state == RD_CP) && (rd_addr == CP_START);
            out_eop   <= rd_done;
        end
    end

    assign out_i = out_valid ? rd_data[2*DW-1:DW] : '0;
    assign out_q = out_valid ? rd_data[DW-1:0]    : '0;

`ifdef OFDM_CP_SYMCNT_EN
    // Count emitted symbols; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_cnt <= 16'd0;
        end else if (out_eop) begin
            sym_cnt <= sym_cnt + 16'd1;
        end
    end
`endif

endmodule
